// File: rtl/mem_bus_pkg.sv
// Shared types and helpers for the word-RAM bus initiator.
package mem_bus_pkg;

  localparam int unsigned WORD_W        = 32;
  localparam int unsigned DEFAULT_DEPTH = 128;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // Request payload held for the duration of a transfer
  typedef struct packed {
    logic              we;
    logic [WORD_W-1:0] wdata;
  } req_t;

  function automatic logic [WORD_W-1:0] word_index(input logic [WORD_W-1:0] addr,
                                                   input logic              byte_addr);
    return byte_addr ? {2'b00, addr[WORD_W-1:2]} : addr;
  endfunction

endpackage

// File: rtl/mem_bus_wait_ctr.sv
// Loadable down-counter with a registered zero flag; paces the ACCESS wait states.
module mem_bus_wait_ctr #(
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          dec_i,
  output logic          zero_o
);

  logic [CW-1:0] count_q, count_d;
  logic          zero_q, zero_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - CW'(1);
    end
    zero_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      zero_q  <= 1'b1;
    end else begin
      count_q <= count_d;
      zero_q  <= zero_d;
    end
  end

  assign zero_o = zero_q;

endmodule

// File: rtl/mem_bus_master.sv
// Bus initiator for the single-port word RAM on a shared tristate data bus.
// Optional address range/alignment checking is enabled by defining MEMBUS_RANGE_CHECK_EN.
module mem_bus_master
  import mem_bus_pkg::*;
#(
  parameter int unsigned DEPTH       = DEFAULT_DEPTH,
  parameter int unsigned BYTE_ADDR   = 1,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_addr,
  inout  wire  [WORD_W-1:0] mem_bus
);

  localparam int unsigned CTR_W = 4;

  if ((WAIT_STATES > 15) || (DEPTH == 0)) begin : g_bad_param
    $error("mem_bus_master: WAIT_STATES must be 0..15 and DEPTH nonzero");
  end

  state_e            state_q, state_d;
  req_t              req_q, req_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic [WORD_W-1:0] mem_addr_q, mem_addr_d;
  logic              err_q, err_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic              cs_q, cs_d;
  logic              mem_we_q, mem_we_d;
  logic [WORD_W-1:0] req_idx;
  logic              addr_bad;
  logic              ctr_load, ctr_dec, ctr_zero;

  assign req_idx = word_index(req_addr, BYTE_ADDR != 0);

`ifdef MEMBUS_RANGE_CHECK_EN
  assign addr_bad = (req_idx >= WORD_W'(DEPTH)) ||
                    ((BYTE_ADDR != 0) && (req_addr[1:0] != 2'b00));
`else
  assign addr_bad = 1'b0;
`endif

  mem_bus_wait_ctr #(.CW(CTR_W)) u_wait_ctr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (ctr_load),
    .load_val_i (CTR_W'(WAIT_STATES)),
    .dec_i      (ctr_dec),
    .zero_o     (ctr_zero)
  );

  // State and registered-output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      req_q        <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      mem_addr_q   <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      cs_q         <= 1'b0;
      mem_we_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      mem_addr_q   <= mem_addr_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      cs_q         <= cs_d;
      mem_we_q     <= mem_we_d;
    end
  end

  // Next-state and transfer datapath
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    ctr_load = 1'b0;
    ctr_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          req_d    = '{we: req_we, wdata: req_wdata};
          rdata_d  = '0;
          err_d    = addr_bad;
          ctr_load = 1'b1;
          state_d  = addr_bad ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (ctr_zero) begin
          rdata_d = req_q.we ? '0 : mem_bus;
          state_d = ST_RESP;
        end else begin
          ctr_dec = 1'b1;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the next state so they launch cleanly from flops
  always_comb begin
    req_ready_d  = (state_d == ST_IDLE);
    resp_valid_d = (state_d == ST_RESP);
    cs_d         = (state_d == ST_ACCESS);
    mem_we_d     = cs_d && req_d.we;
    mem_addr_d   = mem_addr_q;
    if ((state_q == ST_IDLE) && (state_d == ST_ACCESS)) begin
      mem_addr_d = req_idx;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_cs     = cs_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;

  // Bus enable is exactly "store in ACCESS"; reset clears it asynchronously
  assign mem_bus = mem_we_q ? req_q.wdata : {WORD_W{1'bz}};

endmodule

// File: tb/tb_mem_bus_master.sv
// Self-checking bench for mem_bus_master: two instances (0 and 3 wait states), each with a falling-edge RAM model.
module tb_mem_bus_master;

  localparam int unsigned DEPTH = 128;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];
  logic        mem_cs     [2];
  logic        mem_we     [2];
  logic [31:0] mem_addr   [2];
  wire  [31:0] bus0, bus1;

  logic [31:0] ram0 [DEPTH];
  logic [31:0] ram1 [DEPTH];
  logic [31:0] model [2][DEPTH];
  exp_t        exp_q [$];

  int n_checks = 0;
  int n_fail   = 0;

  bit          t_ok;
  int          t_lat, t_cs, t_we, t_bad;
  logic [31:0] t_rdata;
  logic        t_err;

  always #5 clk = ~clk;

  mem_bus_master #(.DEPTH(DEPTH), .BYTE_ADDR(1), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]),
    .mem_cs(mem_cs[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_bus(bus0)
  );

  mem_bus_master #(.DEPTH(DEPTH), .BYTE_ADDR(1), .WAIT_STATES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]),
    .mem_cs(mem_cs[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_bus(bus1)
  );

  // RAM models: drive the bus on reads, write on the falling edge
  assign bus0 = (mem_cs[0] && !mem_we[0]) ? ram0[mem_addr[0][6:0]] : 32'bz;
  assign bus1 = (mem_cs[1] && !mem_we[1]) ? ram1[mem_addr[1][6:0]] : 32'bz;

  always @(negedge clk) begin
    if (mem_cs[0] && mem_we[0]) ram0[mem_addr[0][6:0]] <= bus0;
    if (mem_cs[1] && mem_we[1]) ram1[mem_addr[1][6:0]] <= bus1;
  end

  task automatic drive_req(input int i, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata);
    req_valid[i] = 1'b1;
    req_we[i]    = we;
    req_addr[i]  = addr;
    req_wdata[i] = wdata;
  endtask

  task automatic wait_accept(input int i, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (req_ready[i]) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        return;
      end
    end
  endtask

  // Scoreboard push: expected response derived from the bench's own memory model
  task automatic push_exp(input int i, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata);
    exp_t e;
`ifdef MEMBUS_RANGE_CHECK_EN
    if ((addr[31:2] >= 30'(DEPTH)) || (addr[1:0] != 2'b00)) begin
      e = '{rdata: 32'h0, err: 1'b1};
      exp_q.push_back(e);
      return;
    end
`endif
    if (we) begin
      model[i][addr[8:2]] = wdata;
      e = '{rdata: 32'h0, err: 1'b0};
    end else begin
      e = '{rdata: model[i][addr[8:2]], err: 1'b0};
    end
    exp_q.push_back(e);
  endtask

  task automatic run_txn(input int i, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, output bit ok, output int lat,
                         output int cs_cnt, output int we_cnt, output int bus_bad,
                         output logic [31:0] rdata, output logic err);
    bit          acc;
    logic [31:0] exp_bus;
    logic [31:0] bv;
    ok = 1'b0; lat = 0; cs_cnt = 0; we_cnt = 0; bus_bad = 0; rdata = '0; err = 1'b0;
    drive_req(i, we, addr, wdata);
    wait_accept(i, acc);
    req_valid[i] = 1'b0;
    if (!acc) return;
    push_exp(i, we, addr, wdata);
    exp_bus = we ? wdata : model[i][addr[8:2]];
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      bv = (i == 0) ? bus0 : bus1;
      if (mem_cs[i]) begin
        cs_cnt++;
        if (mem_we[i]) we_cnt++;
        if (bv !== exp_bus) bus_bad++;
      end
      if (resp_valid[i]) begin
        lat = c; rdata = resp_rdata[i]; err = resp_err[i]; ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if ({req_ready[i], resp_valid[i], resp_err[i], mem_cs[i], mem_we[i]} !== 5'b10000) begin
        n_fail++;
        $display("FAIL reset_ctrl[%0d]: got %b expected 10000", i,
                 {req_ready[i], resp_valid[i], resp_err[i], mem_cs[i], mem_we[i]});
      end
      n_checks++;
      if (resp_rdata[i] !== 32'h0) begin
        n_fail++; $display("FAIL reset_rdata[%0d]: got %h expected 0", i, resp_rdata[i]);
      end
      n_checks++;
      if (mem_addr[i] !== 32'h0) begin
        n_fail++; $display("FAIL reset_addr[%0d]: got %h expected 0", i, mem_addr[i]);
      end
    end
  endtask

  task automatic test_store_load();
    exp_t e;
    run_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, t_ok, t_lat, t_cs, t_we, t_bad, t_rdata, t_err);
    n_checks++;
    if (!t_ok || t_lat != 2 || t_cs != 1 || t_we != 1 || t_bad != 0) begin
      n_fail++;
      $display("FAIL st_timing: got ok=%0d lat=%0d cs=%0d we=%0d busbad=%0d expected 1 2 1 1 0",
               t_ok, t_lat, t_cs, t_we, t_bad);
    end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '{rdata: 32'hFFFFFFFF, err: 1'b1};
    n_checks++;
    if ({t_rdata, t_err} !== {e.rdata, e.err}) begin
      n_fail++; $display("FAIL st_resp: got %h/%b expected %h/%b", t_rdata, t_err, e.rdata, e.err);
    end
    n_checks++;
    if (ram0[4] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL st_ram_word4: got %h expected deadbeef", ram0[4]);
    end
    run_txn(0, 1'b0, 32'h10, 32'h0, t_ok, t_lat, t_cs, t_we, t_bad, t_rdata, t_err);
    n_checks++;
    if (!t_ok || t_lat != 2 || t_cs != 1 || t_we != 0 || t_bad != 0) begin
      n_fail++;
      $display("FAIL ld_timing: got ok=%0d lat=%0d cs=%0d we=%0d busbad=%0d expected 1 2 1 0 0",
               t_ok, t_lat, t_cs, t_we, t_bad);
    end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '{rdata: 32'hFFFFFFFF, err: 1'b1};
    n_checks++;
    if ({t_rdata, t_err} !== {e.rdata, e.err} || t_rdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL ld_resp: got %h/%b expected %h/%b", t_rdata, t_err, e.rdata, e.err);
    end
  endtask

  task automatic test_backpressure();
    bit   acc;
    bit   seen;
    int   stable_bad;
    exp_t e;
    resp_ready[0] = 1'b0;
    drive_req(0, 1'b0, 32'h10, 32'h0);
    wait_accept(0, acc);
    if (acc) push_exp(0, 1'b0, 32'h10, 32'h0);
    drive_req(0, 1'b1, 32'h40, 32'hBAD0BAD0);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (resp_valid[0]) begin seen = 1'b1; break; end
    end
    n_checks++;
    if (!acc || !seen || exp_q.size() == 0) begin
      n_fail++; $display("FAIL bp_resp_seen: got acc=%0d seen=%0d expected 1 1", acc, seen);
    end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '{rdata: 32'hFFFFFFFF, err: 1'b1};
    stable_bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (!resp_valid[0] || resp_rdata[0] !== e.rdata || req_ready[0] || mem_cs[0]) stable_bad++;
    end
    n_checks++;
    if (stable_bad != 0) begin
      n_fail++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", stable_bad);
    end
    n_checks++;
    if (mem_addr[0] !== 32'h4) begin
      n_fail++; $display("FAIL bp_addr_hold: got %h expected 4", mem_addr[0]);
    end
    req_valid[0]  = 1'b0;
    resp_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (resp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
      n_fail++; $display("FAIL bp_release: got valid=%b ready=%b expected 0 1", resp_valid[0], req_ready[0]);
    end
  endtask

  task automatic test_wait_states();
    exp_t e;
    run_txn(1, 1'b1, 32'h14, 32'h12345678, t_ok, t_lat, t_cs, t_we, t_bad, t_rdata, t_err);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    n_checks++;
    if (!t_ok || t_lat != 5 || t_cs != 4 || t_we != 4 || t_bad != 0) begin
      n_fail++;
      $display("FAIL ws_store: got ok=%0d lat=%0d cs=%0d we=%0d busbad=%0d expected 1 5 4 4 0",
               t_ok, t_lat, t_cs, t_we, t_bad);
    end
    run_txn(1, 1'b0, 32'h14, 32'h0, t_ok, t_lat, t_cs, t_we, t_bad, t_rdata, t_err);
    n_checks++;
    if (!t_ok || t_lat != 5 || t_cs != 4 || t_we != 0 || t_bad != 0) begin
      n_fail++;
      $display("FAIL ws_load: got ok=%0d lat=%0d cs=%0d we=%0d busbad=%0d expected 1 5 4 0 0",
               t_ok, t_lat, t_cs, t_we, t_bad);
    end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '{rdata: 32'hFFFFFFFF, err: 1'b1};
    n_checks++;
    if ({t_rdata, t_err} !== {e.rdata, e.err} || t_rdata !== 32'h12345678) begin
      n_fail++; $display("FAIL ws_rdata: got %h/%b expected 12345678/0", t_rdata, t_err);
    end
  endtask

  task automatic test_back_to_back();
    int resp_cnt = 0;
    int match    = 0;
    int cs_cyc   = 0;
    int cs_adj   = 0;
    bit done     = 1'b0;
    bit timeout  = 1'b0;
    fork
      begin : drv
        bit acc;
        req_valid[0] = 1'b1;
        for (int k = 0; k < 16; k++) begin
          req_we[0]    = (k % 2 == 0);
          req_addr[0]  = 32'((k / 2) * 4);
          req_wdata[0] = 32'hC0DE0000 + 32'(k);
          wait_accept(0, acc);
          if (!acc) begin timeout = 1'b1; break; end
          push_exp(0, (k % 2 == 0), 32'((k / 2) * 4), 32'hC0DE0000 + 32'(k));
        end
        req_valid[0] = 1'b0;
      end
      begin : col
        bit   seen;
        exp_t e;
        for (int r = 0; r < 16 && !timeout; r++) begin
          seen = 1'b0;
          for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (resp_valid[0]) begin seen = 1'b1; break; end
          end
          if (!seen || exp_q.size() == 0) begin timeout = 1'b1; break; end
          e = exp_q.pop_front();
          resp_cnt++;
          if (resp_rdata[0] === e.rdata && resp_err[0] === e.err) match++;
          @(posedge clk);
        end
        done = 1'b1;
      end
      begin : mon
        bit prev = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
          @(negedge clk);
          if (mem_cs[0]) begin
            cs_cyc++;
            if (prev) cs_adj++;
          end
          prev = mem_cs[0];
        end
      end
    join
    #1;
    n_checks++;
    if (timeout || resp_cnt != 16) begin
      n_fail++; $display("FAIL b2b_count: got %0d responses timeout=%0d expected 16 0", resp_cnt, timeout);
    end
    n_checks++;
    if (match != 16) begin
      n_fail++; $display("FAIL b2b_readback: got %0d matching expected 16", match);
    end
    n_checks++;
    if (cs_cyc != 16 || cs_adj != 0) begin
      n_fail++; $display("FAIL b2b_bus_gap: got cs_cycles=%0d adjacent=%0d expected 16 0", cs_cyc, cs_adj);
    end
  endtask

  task automatic test_async_reset();
    bit acc;
    run_txn(0, 1'b1, 32'h24, 32'h11111111, t_ok, t_lat, t_cs, t_we, t_bad, t_rdata, t_err);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    drive_req(0, 1'b1, 32'h24, 32'h5555AAAA);
    wait_accept(0, acc);
    req_valid[0] = 1'b0;
    n_checks++;
    if (!acc || mem_cs[0] !== 1'b1) begin
      n_fail++; $display("FAIL ar_in_access: got acc=%0d cs=%b expected 1 1", acc, mem_cs[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({mem_cs[0], mem_we[0], resp_valid[0], req_ready[0]} !== 4'b0001) begin
      n_fail++;
      $display("FAIL ar_immediate: got %b expected 0001", {mem_cs[0], mem_we[0], resp_valid[0], req_ready[0]});
    end
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (ram0[9] !== 32'h11111111) begin
      n_fail++; $display("FAIL ar_write_aborted: got %h expected 11111111", ram0[9]);
    end
    n_checks++;
    if (req_ready[0] !== 1'b1 || resp_valid[0] !== 1'b0 || mem_addr[0] !== 32'h0) begin
      n_fail++;
      $display("FAIL ar_idle: got ready=%b valid=%b addr=%h expected 1 0 0", req_ready[0], resp_valid[0], mem_addr[0]);
    end
  endtask

  task automatic test_range_check();
    exp_t e;
    run_txn(0, 1'b0, 32'h200, 32'h0, t_ok, t_lat, t_cs, t_we, t_bad, t_rdata, t_err);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '{rdata: 32'hFFFFFFFF, err: 1'b1};
    n_checks++;
    if (!t_ok || {t_rdata, t_err} !== {e.rdata, e.err}) begin
      n_fail++; $display("FAIL rc_word128: got %h/%b expected %h/%b", t_rdata, t_err, e.rdata, e.err);
    end
`ifdef MEMBUS_RANGE_CHECK_EN
    n_checks++;
    if (t_lat != 1 || t_cs != 0) begin
      n_fail++; $display("FAIL rc_word128_timing: got lat=%0d cs=%0d expected 1 0", t_lat, t_cs);
    end
    run_txn(0, 1'b0, 32'h3, 32'h0, t_ok, t_lat, t_cs, t_we, t_bad, t_rdata, t_err);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '{rdata: 32'hFFFFFFFF, err: 1'b0};
    n_checks++;
    if (!t_ok || t_err !== 1'b1 || {t_rdata, t_err} !== {e.rdata, e.err} || t_cs != 0) begin
      n_fail++; $display("FAIL rc_misaligned: got %h/%b cs=%0d expected 0/1 0", t_rdata, t_err, t_cs);
    end
`else
    n_checks++;
    if (t_err !== 1'b0 || t_lat != 2 || t_cs != 1) begin
      n_fail++; $display("FAIL rc_disabled: got err=%b lat=%0d cs=%0d expected 0 2 1", t_err, t_lat, t_cs);
    end
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i]  = 1'b0;
      req_we[i]     = 1'b0;
      req_addr[i]   = '0;
      req_wdata[i]  = '0;
      resp_ready[i] = 1'b1;
    end
    #12;
    test_reset();
    rst_n = 1'b1;
    test_store_load();
    test_backpressure();
    test_wait_states();
    test_back_to_back();
    test_async_reset();
    test_range_check();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
